// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction memory port sequencer: byte loader, PC, stalls, branch redirects
// Shares one memory port between the program loader and the 32-bit big-endian fetch path.
module imem_fetch_ctrl #(
    parameter int          ADDR_W   = 11,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    input  logic              fetch_stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic              mem_en,
    output logic [31:0]       mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_instr,
    output logic              if_valid,
    output logic [1:0]        state_o,
    output logic              addr_err,
    output logic [ADDR_W:0]   ld_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_HALT = 2'b11
    } state_t;

    // Highest PC whose 4-byte word still fits inside the memory
    localparam logic [31:0]     PC_MAX  = 32'((64'd1 << ADDR_W) - 64'd4);
    localparam logic [ADDR_W:0] CNT_MAX = '1;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pc_bad;
    logic        ld_fire;

    always_comb begin
        ld_ready  = (state == S_LOAD);
        ld_fire   = ld_ready && ld_valid;
        mem_we    = ld_fire;
        mem_wdata = ld_fire ? ld_data : 8'h00;
        mem_en    = (state == S_RUN) && !fetch_stall;
        mem_addr  = 32'h0;
        if (state == S_LOAD)
            mem_addr = {{(32-ADDR_W){1'b0}}, ld_addr};
        else if (state == S_RUN)
            mem_addr = pc;
        next_pc = branch_taken ? branch_target : pc + 32'd4;
        pc_bad  = (next_pc[1:0] != 2'b00) || (next_pc > PC_MAX);
        state_o = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            if_pc    <= 32'h0;
            if_instr <= 32'h0;
            if_valid <= 1'b0;
            addr_err <= 1'b0;
            ld_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (load_start) begin
                        state    <= S_LOAD;
                        ld_count <= '0;
                        if_valid <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ld_fire) begin
                        if (ld_count != CNT_MAX)
                            ld_count <= ld_count + 1'b1;
                        if (ld_last) begin
                            state    <= S_RUN;
                            pc       <= RESET_PC;
                            addr_err <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (load_start) begin
                        state    <= S_LOAD;
                        ld_count <= '0;
                        if_valid <= 1'b0;
                    end else if (fetch_stall) begin
                        // A redirect under stall flushes IF but still moves the PC
                        if (branch_taken) begin
                            if_valid <= 1'b0;
                            if (pc_bad) begin
                                state    <= S_HALT;
                                addr_err <= 1'b1;
                            end else begin
                                pc <= next_pc;
                            end
                        end
                    end else begin
                        if_instr <= mem_rdata;
                        if_pc    <= pc;
                        if_valid <= !pc_bad;
                        if (pc_bad) begin
                            state    <= S_HALT;
                            addr_err <= 1'b1;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [10:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        ld_last = 1'b0;
    logic        fetch_stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic [1:0]  state_o;
    logic        addr_err;
    logic [11:0] ld_count;

    int total = 0;
    int bad = 0;

    logic [7:0] mem [0:2047];

    imem_fetch_ctrl #(.ADDR_W(11), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last), .fetch_stall(fetch_stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .if_pc(if_pc),
        .if_instr(if_instr), .if_valid(if_valid), .state_o(state_o),
        .addr_err(addr_err), .ld_count(ld_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_rdata = {mem[mem_addr[10:0]], mem[11'(mem_addr[10:0] + 11'd1)],
                     mem[11'(mem_addr[10:0] + 11'd2)], mem[11'(mem_addr[10:0] + 11'd3)]};
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[10:0]] = mem_wdata;
    end

    function automatic logic [7:0] pb(int a);
        return 8'(a) ^ 8'hA5;
    endfunction

    function automatic logic [31:0] pw(int a);
        return {pb(a), pb(a + 1), pb(a + 2), pb(a + 3)};
    endfunction

    task automatic test_reset;
        #12;
        total++; if (state_o !== 2'b00) begin bad++; $display("FAIL rst_state got=%0h exp=0", state_o); end
        total++; if (ld_ready !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL rst_strobes ready=%b en=%b we=%b exp=000", ld_ready, mem_en, mem_we); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
        total++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin bad++; $display("FAIL rst_if valid=%b pc=%0h instr=%0h exp=0", if_valid, if_pc, if_instr); end
        total++; if (addr_err !== 1'b0 || ld_count !== 12'd0) begin bad++; $display("FAIL rst_err_cnt err=%b cnt=%0d exp=0", addr_err, ld_count); end
        @(negedge clk); rst = 1'b0;
        ld_valid = 1'b1; ld_addr = 11'h30; ld_data = 8'h77;
        #1;
        total++; if (ld_ready !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL idle_drop ready=%b we=%b exp=00", ld_ready, mem_we); end
        @(negedge clk); ld_valid = 1'b0;
        total++; if (state_o !== 2'b00) begin bad++; $display("FAIL idle_stay got=%0h exp=0", state_o); end
    endtask

    task automatic test_reset_mid_load;
        load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        total++; if (state_o !== 2'b01) begin bad++; $display("FAIL enter_load got=%0h exp=1", state_o); end
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_addr = 11'(32'h20 + i); ld_data = 8'(8'h11 + i);
            #1;
            total++; if (mem_we !== 1'b1 || mem_addr !== 32'(32'h20 + i) || mem_wdata !== 8'(8'h11 + i)) begin bad++; $display("FAIL load_wr%0d we=%b addr=%0h data=%0h", i, mem_we, mem_addr, mem_wdata); end
            @(negedge clk);
        end
        total++; if (ld_count !== 12'd3) begin bad++; $display("FAIL cnt3 got=%0d exp=3", ld_count); end
        #2 rst = 1'b1;
        #1;
        total++; if (state_o !== 2'b00 || ld_count !== 12'd0) begin bad++; $display("FAIL midload_rst state=%0h cnt=%0d exp=0,0", state_o, ld_count); end
        total++; if (mem_we !== 1'b0 || ld_ready !== 1'b0) begin bad++; $display("FAIL midload_rst_strb we=%b ready=%b exp=00", mem_we, ld_ready); end
        @(negedge clk); rst = 1'b0; ld_valid = 1'b0;
    endtask

    task automatic test_load_run;
        load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1; ld_addr = 11'(i); ld_data = 8'(i); ld_last = (i == 7);
            @(negedge clk);
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        total++; if (state_o !== 2'b10 || ld_count !== 12'd8) begin bad++; $display("FAIL load_done state=%0h cnt=%0d exp=2,8", state_o, ld_count); end
        total++; if (if_valid !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL run_first valid=%b en=%b addr=%0h exp=0,1,0", if_valid, mem_en, mem_addr); end
        @(negedge clk);
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h00010203) begin bad++; $display("FAIL fetch0 valid=%b pc=%0h instr=%0h exp=1,0,00010203", if_valid, if_pc, if_instr); end
        @(negedge clk);
        total++; if (if_pc !== 32'h4 || if_instr !== 32'h04050607) begin bad++; $display("FAIL fetch4 pc=%0h instr=%0h exp=4,04050607", if_pc, if_instr); end
    endtask

    task automatic test_stall;
        fetch_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL stall_en%0d got=%b exp=0", i, mem_en); end
            @(negedge clk);
            total++; if (if_pc !== 32'h4 || if_instr !== 32'h04050607 || if_valid !== 1'b1) begin bad++; $display("FAIL stall_hold%0d pc=%0h instr=%0h valid=%b", i, if_pc, if_instr, if_valid); end
        end
        fetch_stall = 1'b0;
        @(negedge clk);
        total++; if (if_pc !== 32'h8 || if_instr !== pw(8)) begin bad++; $display("FAIL resume8 pc=%0h instr=%0h exp=8,%0h", if_pc, if_instr, pw(8)); end
        @(negedge clk);
        total++; if (if_pc !== 32'hC || if_instr !== pw(12)) begin bad++; $display("FAIL resumeC pc=%0h instr=%0h exp=c,%0h", if_pc, if_instr, pw(12)); end
    endtask

    task automatic test_branch_stall;
        fetch_stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        @(negedge clk); fetch_stall = 1'b0; branch_taken = 1'b0;
        total++; if (if_valid !== 1'b0 || state_o !== 2'b10) begin bad++; $display("FAIL br_flush valid=%b state=%0h exp=0,2", if_valid, state_o); end
        @(negedge clk);
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== pw(32'h40)) begin bad++; $display("FAIL br_target valid=%b pc=%0h instr=%0h", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_fault_reload;
        branch_taken = 1'b1; branch_target = 32'h42;
        @(negedge clk); branch_taken = 1'b0;
        total++; if (state_o !== 2'b11 || addr_err !== 1'b1 || if_valid !== 1'b0) begin bad++; $display("FAIL misalign state=%0h err=%b valid=%b exp=3,1,0", state_o, addr_err, if_valid); end
        @(negedge clk);
        total++; if (state_o !== 2'b11 || mem_en !== 1'b0) begin bad++; $display("FAIL halt_hold state=%0h en=%b exp=3,0", state_o, mem_en); end
        load_start = 1'b1; ld_valid = 1'b1; ld_addr = 11'h10; ld_data = 8'h99;
        #1;
        total++; if (ld_ready !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL halt_drop ready=%b we=%b exp=00", ld_ready, mem_we); end
        @(negedge clk); load_start = 1'b0; ld_valid = 1'b0;
        total++; if (state_o !== 2'b01 || ld_count !== 12'd0 || addr_err !== 1'b1) begin bad++; $display("FAIL reload state=%0h cnt=%0d err=%b exp=1,0,1", state_o, ld_count, addr_err); end
        total++; if (mem[11'h10] !== pb(32'h10)) begin bad++; $display("FAIL dropped_byte got=%0h exp=%0h", mem[11'h10], pb(32'h10)); end
        ld_valid = 1'b1; ld_addr = 11'h100; ld_data = 8'h5A; ld_last = 1'b1;
        @(negedge clk); ld_valid = 1'b0; ld_last = 1'b0;
        total++; if (state_o !== 2'b10 || addr_err !== 1'b0 || ld_count !== 12'd1) begin bad++; $display("FAIL session_end state=%0h err=%b cnt=%0d exp=2,0,1", state_o, addr_err, ld_count); end
        total++; if (mem[11'h100] !== 8'h5A) begin bad++; $display("FAIL byte_written got=%0h exp=5a", mem[11'h100]); end
    endtask

    task automatic test_range_fault;
        branch_taken = 1'b1; branch_target = 32'h7F8;
        @(negedge clk); branch_taken = 1'b0;
        total++; if (if_pc !== 32'h0 || if_instr !== 32'h00010203) begin bad++; $display("FAIL run_pc0 pc=%0h instr=%0h exp=0,00010203", if_pc, if_instr); end
        @(negedge clk);
        total++; if (state_o !== 2'b10 || if_pc !== 32'h7F8 || if_instr !== pw(32'h7F8) || if_valid !== 1'b1) begin bad++; $display("FAIL edge7f8 state=%0h pc=%0h instr=%0h valid=%b", state_o, if_pc, if_instr, if_valid); end
        @(negedge clk);
        total++; if (state_o !== 2'b11 || addr_err !== 1'b1 || if_valid !== 1'b0) begin bad++; $display("FAIL range state=%0h err=%b valid=%b exp=3,1,0", state_o, addr_err, if_valid); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = pb(i);
        test_reset;
        test_reset_mid_load;
        test_load_run;
        test_stall;
        test_branch_stall;
        test_fault_reload;
        test_range_fault;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
